// File: rtl/dstack_spill.sv
// dstack_spill: spill/fill engine under the bottom of the core0 data stack.
//
// Words pushed off the dstack bottom land in a small ring buffer. The oldest
// buffered words drain to a LIFO spill region in memory in the background.
// Pops (fills) return the newest buffered word, and the buffer is refilled
// from memory when it runs low. Together with the dstack this behaves as one
// deep LIFO backed by memory.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   spill_base           byte base of the spill region (static while mem_count != 0)
//   spill_valid/data     word lost from the dstack bottom this cycle
//   spill_ready          buffer can take a spill; a spill while low is dropped
//   fill_req             dstack wants its bottom refilled, held until fill_ack
//   fill_ack/data        combinational response carrying the newest word
//   mem_req/we/addr/wdata  memory request, held with stable fields until mem_ack
//   mem_ack/rdata        memory completion at this edge, read data
//   buf_count            valid buffer entries
//   mem_count            words held in the spill region
//   overflow/underflow   one-cycle pulses: spill dropped / fill with nothing stored
//   fsm_state            current engine state (0 idle, 1 write, 2 read)
//
// Handshakes: a spill is taken on any edge where spill_valid && spill_ready;
// a fill is taken on any edge where fill_req && fill_ack; a memory transfer
// completes on any edge where mem_req && mem_ack. No side ever stalls the
// dstack, so a spill presented while spill_ready is low is lost.
module dstack_spill #(
  parameter int WIDTH         = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int BUF_DEPTH_MAG = 2,
  parameter int MEM_WORDS     = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_WIDTH-1:0]    spill_base,
  input  logic                     spill_valid,
  input  logic [WIDTH-1:0]         spill_data,
  output logic                     spill_ready,
  input  logic                     fill_req,
  output logic                     fill_ack,
  output logic [WIDTH-1:0]         fill_data,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic                     mem_ack,
  input  logic [WIDTH-1:0]         mem_rdata,
  output logic [BUF_DEPTH_MAG:0]   buf_count,
  output logic [ADDR_WIDTH-1:0]    mem_count,
  output logic                     overflow,
  output logic                     underflow,
  output logic [1:0]               fsm_state
);

  localparam int BUF_DEPTH = 1 << BUF_DEPTH_MAG;
  localparam int CW        = BUF_DEPTH_MAG + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                   state;
  logic [WIDTH-1:0]         buf_mem [BUF_DEPTH];
  logic [BUF_DEPTH_MAG-1:0] head;
  logic [BUF_DEPTH_MAG-1:0] tail;
  logic [CW-1:0]            count_q;
  logic [ADDR_WIDTH-1:0]    mcount_q;

  logic [BUF_DEPTH_MAG-1:0] head_m1;
  logic [BUF_DEPTH_MAG-1:0] tail_m1;
  logic [CW-1:0]            avail;
  logic [CW:0]              occupied;
  logic                     spill_acc;
  logic                     fill_acc;
  logic                     wr_done;
  logic                     rd_done;
  logic                     want_write;
  logic                     want_read;
  logic [CW-1:0]            cnt_inc;
  logic [CW-1:0]            cnt_dec;

  assign head_m1 = head - 1'b1;
  assign tail_m1 = tail - 1'b1;

  // While a drain is in flight the tail entry is still counted but belongs to
  // the memory write, so it cannot be handed to the dstack.
  assign avail    = count_q - ((state == WRITE) ? CW'(1) : CW'(0));
  // A pending refill owns slot tail-1, so it counts against free space.
  assign occupied = (CW+1)'(count_q) + ((state == READ) ? (CW+1)'(1) : (CW+1)'(0));

  assign fill_ack    = fill_req && (avail != '0);
  assign fill_data   = buf_mem[head_m1];
  assign spill_ready = (occupied < (CW+1)'(BUF_DEPTH));

  assign spill_acc = spill_valid && spill_ready;
  assign fill_acc  = fill_ack;
  assign wr_done   = (state == WRITE) && mem_ack;
  assign rd_done   = (state == READ) && mem_ack;

  assign want_write = (count_q >= CW'(BUF_DEPTH - 1)) && (mcount_q < ADDR_WIDTH'(MEM_WORDS));
  assign want_read  = (count_q <= CW'(1)) && (mcount_q != '0);

  // A simultaneous spill and fill cancel out in the count.
  assign cnt_inc = ((spill_acc && !fill_acc) ? CW'(1) : CW'(0)) + (rd_done ? CW'(1) : CW'(0));
  assign cnt_dec = ((fill_acc && !spill_acc) ? CW'(1) : CW'(0)) + (wr_done ? CW'(1) : CW'(0));

  assign buf_count = count_q;
  assign mem_count = mcount_q;
  assign fsm_state = state;

  // Buffer storage. Spill and refill target distinct slots: a refill is only
  // pending when spill_ready leaves at least two free slots.
  always_ff @(posedge clk) begin
    if (spill_acc && fill_acc) begin
      buf_mem[head_m1] <= spill_data;
    end else if (spill_acc) begin
      buf_mem[head] <= spill_data;
    end
    if (rd_done) begin
      buf_mem[tail_m1] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      mcount_q  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= spill_valid && !spill_ready;
      underflow <= fill_req && (count_q == '0) && (mcount_q == '0) && (state == IDLE);

      if (spill_acc && !fill_acc) begin
        head <= head + 1'b1;
      end else if (fill_acc && !spill_acc) begin
        head <= head_m1;
      end
      count_q <= count_q + cnt_inc - cnt_dec;

      case (state)
        IDLE: begin
          if (want_write) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= spill_base + (mcount_q << 2);
            mem_wdata <= buf_mem[tail];
          end else if (want_read) begin
            state    <= READ;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= spill_base + ((mcount_q - 1'b1) << 2);
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            tail     <= tail + 1'b1;
            mcount_q <= mcount_q + 1'b1;
          end
        end
        READ: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            tail     <= tail_m1;
            mcount_q <= mcount_q - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dstack_spill.sv
// Directed bench for dstack_spill (BUF_DEPTH=4, MEM_WORDS=2, spill_base=0x1000).
// Expected fill words and memory transactions are queued by the stimulus and
// checked by independent monitors when the DUT presents them.
module tb_dstack_spill;

  logic        clk;
  logic        reset_n;
  logic [31:0] spill_base;
  logic        spill_valid;
  logic [31:0] spill_data;
  logic        spill_ready;
  logic        fill_req;
  logic        fill_ack;
  logic [31:0] fill_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [2:0]  buf_count;
  logic [31:0] mem_count;
  logic        overflow;
  logic        underflow;
  logic [1:0]  fsm_state;

  dstack_spill #(
    .WIDTH(32), .ADDR_WIDTH(32), .BUF_DEPTH_MAG(2), .MEM_WORDS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .spill_base(spill_base),
    .spill_valid(spill_valid), .spill_data(spill_data), .spill_ready(spill_ready),
    .fill_req(fill_req), .fill_ack(fill_ack), .fill_data(fill_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .buf_count(buf_count), .mem_count(mem_count),
    .overflow(overflow), .underflow(underflow), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] fill_exp_q[$];
  logic [64:0] mem_exp_q[$];   // {we, addr, wdata-or-0}
  logic [31:0] mem_model [8];
  int          total = 0;
  int          bad = 0;
  int          mem_lat = 2;
  int          ovf_seen = 0;
  int          unf_seen = 0;

  function automatic void check(input string name, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Fill monitor: every accepted fill must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && fill_req && fill_ack) begin
      if (fill_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fill_unexpected: got=%0h expected=none", fill_data);
      end else begin
        check("fill_data", 72'(fill_data), 72'(fill_exp_q.pop_front()));
      end
    end
    if (reset_n && overflow) ovf_seen++;
    if (reset_n && underflow) unf_seen++;
  end

  // Memory responder and transaction monitor.
  initial begin
    int          lat_cnt;
    int          idx;
    logic [64:0] e;
    mem_ack = 1'b0;
    mem_rdata = '0;
    lat_cnt = 0;
    for (int i = 0; i < 8; i++) mem_model[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!reset_n || !mem_req) begin
        lat_cnt = 0;
      end else begin
        lat_cnt++;
        if (lat_cnt >= mem_lat) begin
          lat_cnt = 0;
          mem_ack = 1'b1;
          if (mem_exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mem_unexpected: we=%0b addr=%0h", mem_we, mem_addr);
          end else begin
            e = mem_exp_q.pop_front();
            check("mem_txn", 72'({mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)}), 72'(e));
          end
          idx = int'((mem_addr - 32'h1000) >> 2) & 7;
          if (mem_we) mem_model[idx] = mem_wdata;
          else        mem_rdata = mem_model[idx];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_spill(input logic [31:0] d, input logic exp_ovf);
    spill_valid = 1'b1;
    spill_data  = d;
    tick();
    spill_valid = 1'b0;
    check("overflow_pulse", 72'(overflow), 72'(exp_ovf));
  endtask

  task automatic do_fill(input logic [31:0] exp);
    bit got;
    got = 1'b0;
    fill_exp_q.push_back(exp);
    fill_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = fill_ack;
      tick();
    end
    fill_req = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL fill_timeout: got=no_ack expected=%0h", exp);
      void'(fill_exp_q.pop_back());
    end
  endtask

  task automatic do_both(input logic [31:0] d, input logic [31:0] exp);
    fill_exp_q.push_back(exp);
    spill_valid = 1'b1;
    spill_data  = d;
    fill_req    = 1'b1;
    @(negedge clk);
    check("both_fill_ack", 72'(fill_ack), 72'(1));
    tick();
    spill_valid = 1'b0;
    fill_req    = 1'b0;
  endtask

  task automatic wait_mem_count(input logic [31:0] n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mem_count == n) ok = 1'b1;
      else tick();
    end
    check("wait_mem_count", 72'(mem_count), 72'(n));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n     = 1'b0;
    spill_base  = 32'h1000;
    spill_valid = 1'b0;
    spill_data  = '0;
    fill_req    = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_buf_count", 72'(buf_count), 72'(0));
    check("rst_mem_count", 72'(mem_count), 72'(0));
    check("rst_mem_req", 72'(mem_req), 72'(0));
    check("rst_spill_ready", 72'(spill_ready), 72'(1));
    check("rst_state", 72'(fsm_state), 72'(0));

    // Fill with nothing stored: underflow once, no ack, no memory traffic
    fill_req = 1'b1;
    @(negedge clk);
    check("unf_no_ack", 72'(fill_ack), 72'(0));
    tick();
    fill_req = 1'b0;
    check("unf_pulse", 72'(underflow), 72'(1));
    tick();
    check("unf_clear", 72'(underflow), 72'(0));
    check("unf_no_mem_req", 72'(mem_req), 72'(0));

    // Three spills trigger a drain of the oldest word (2-cycle memory)
    mem_lat = 2;
    mem_exp_q.push_back({1'b1, 32'h1000, 32'hA});
    do_spill(32'hA, 1'b0);
    do_spill(32'hB, 1'b0);
    do_spill(32'hC, 1'b0);
    check("pre_drain_req", 72'(mem_req), 72'(0));
    tick();
    check("drain_req", 72'(mem_req), 72'(1));
    check("drain_we", 72'(mem_we), 72'(1));
    check("drain_addr", 72'(mem_addr), 72'(32'h1000));
    check("drain_wdata", 72'(mem_wdata), 72'(32'hA));
    check("drain_state", 72'(fsm_state), 72'(1));
    wait_mem_count(1);
    check("drain_buf_count", 72'(buf_count), 72'(2));
    check("drain_req_drop", 72'(mem_req), 72'(0));

    // Three fills: C and B from the buffer, A refilled from 0x1000
    mem_exp_q.push_back({1'b0, 32'h1000, 32'h0});
    do_fill(32'hC);
    do_fill(32'hB);
    do_fill(32'hA);
    check("fill3_buf_count", 72'(buf_count), 72'(0));
    check("fill3_mem_count", 72'(mem_count), 72'(0));

    // Spill and fill in the same cycle
    do_spill(32'h11, 1'b0);
    do_spill(32'h12, 1'b0);
    do_both(32'hD, 32'h12);
    check("both_buf_count", 72'(buf_count), 72'(2));
    do_fill(32'hD);
    do_fill(32'h11);
    check("both_buf_empty", 72'(buf_count), 72'(0));

    // Eight spills with single-cycle memory; drains complete between spills
    mem_lat = 1;
    mem_exp_q.push_back({1'b1, 32'h1000, 32'h21});
    mem_exp_q.push_back({1'b1, 32'h1004, 32'h22});
    for (int k = 0; k < 8; k++) begin
      do_spill(32'h21 + 32'(k), (k >= 6) ? 1'b1 : 1'b0);
      tick();
      tick();
    end
    check("ovf_mem_count", 72'(mem_count), 72'(2));
    check("ovf_buf_count", 72'(buf_count), 72'(4));
    check("ovf_spill_ready", 72'(spill_ready), 72'(0));

    // Drain everything back in LIFO order
    mem_exp_q.push_back({1'b0, 32'h1004, 32'h0});
    mem_exp_q.push_back({1'b0, 32'h1000, 32'h0});
    for (int k = 5; k >= 0; k--) do_fill(32'h21 + 32'(k));
    check("lifo_buf_count", 72'(buf_count), 72'(0));
    check("lifo_mem_count", 72'(mem_count), 72'(0));

    // Reset in the middle of a write with one word already in memory
    mem_exp_q.push_back({1'b1, 32'h1000, 32'h31});
    do_spill(32'h31, 1'b0);
    do_spill(32'h32, 1'b0);
    do_spill(32'h33, 1'b0);
    wait_mem_count(1);
    tick();
    mem_lat = 20;
    do_spill(32'h34, 1'b0);
    tick();
    check("mid_write_req", 72'(mem_req), 72'(1));
    check("mid_write_addr", 72'(mem_addr), 72'(32'h1004));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_req", 72'(mem_req), 72'(0));
    check("async_rst_buf", 72'(buf_count), 72'(0));
    tick();
    reset_n = 1'b1;
    mem_lat = 2;
    tick();
    check("post_rst_buf", 72'(buf_count), 72'(0));
    check("post_rst_mem", 72'(mem_count), 72'(0));
    check("post_rst_req", 72'(mem_req), 72'(0));
    check("post_rst_state", 72'(fsm_state), 72'(0));
    tick();
    tick();

    // Final accounting
    check("fill_q_empty", 72'(fill_exp_q.size()), 72'(0));
    check("mem_q_empty", 72'(mem_exp_q.size()), 72'(0));
    check("ovf_total", 72'(ovf_seen), 72'(2));
    check("unf_total", 72'(unf_seen), 72'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dstack_spill.md
# dstack_spill

Spill/fill engine at the bottom of the core0 data stack. Words pushed off the bottom of the dstack go into a small on-chip deque buffer; the oldest buffered words drain to a memory spill region in the background. On pops the engine returns the newest word and refills the buffer from memory. The dstack plus this block behaves as one deep LIFO backed by memory.

## Interface

Parameters:
- WIDTH, 32, word width; must be 32 (memory stride 4 bytes)
- ADDR_WIDTH, 32, memory address width
- BUF_DEPTH_MAG, 2, log2 of buffer entries; BUF_DEPTH = 1 << BUF_DEPTH_MAG, minimum 4
- MEM_WORDS, 1024, capacity of the spill region in words

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- spill_base  in  ADDR_WIDTH  byte base of spill region; static while mem_count != 0
- spill_valid  in  1  word lost from dstack bottom this cycle
- spill_data  in  WIDTH  that word
- spill_ready  out  1  buffer can accept a spill (informational; the dstack never stalls)
- fill_req  in  1  dstack needs its bottom refilled; held until fill_ack
- fill_ack  out  1  combinational; fill_data valid this cycle
- fill_data  out  WIDTH  newest buffered word
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write (drain), 0 = read (refill)
- mem_addr  out  ADDR_WIDTH  byte address
- mem_wdata  out  WIDTH  write data
- mem_ack  in  1  request completes at this edge; mem_rdata valid
- mem_rdata  in  WIDTH  read data
- buf_count  out  BUF_DEPTH_MAG+1  valid buffer entries
- mem_count  out  ADDR_WIDTH  words held in memory
- overflow  out  1  one-cycle pulse: spill dropped
- underflow  out  1  one-cycle pulse: fill with nothing stored

## Operation

- Buffer: ring of BUF_DEPTH entries, head = newest and tail = oldest. Spills write at head. Fills read head-1. Drains take tail. Refills write tail-1.
- Memory region is a LIFO: a drain writes spill_base + 4*mem_count then increments mem_count. A refill reads spill_base + 4*(mem_count-1) then decrements mem_count.
- FSM states IDLE, WRITE, READ. Decisions are made in IDLE only.
  - IDLE -> WRITE when buf_count >= BUF_DEPTH-1 and mem_count < MEM_WORDS. Latch tail data into mem_wdata and reserve the tail entry.
  - IDLE -> READ when buf_count <= 1 and mem_count > 0. Reserve slot tail-1.
  - WRITE and READ both return to IDLE on mem_ack. On that same edge, update tail, buf_count and mem_count.
  - After every ack, spend at least one cycle in IDLE.
- fill_ack = fill_req and (buf_count minus reserved WRITE entry) > 0.
- spill_ready = buf_count + (state==READ) < BUF_DEPTH.
- spill_valid with spill_ready low: drop the word and pulse overflow.
- fill_req with buf_count==0, mem_count==0 and state IDLE: pulse underflow; no ack.
- fill_req with an empty buffer but a refill possible or pending: ack is withheld until the refill lands.
- Spill and fill accepted in the same cycle: fill returns the pre-existing newest word, and the spilled word replaces it in that slot. buf_count is unchanged.

## Timing

- Reset (asynchronous, immediate) clears state to IDLE, the buffer pointers, buf_count, mem_count, mem_req, mem_we, mem_addr, mem_wdata, overflow and underflow, all to 0. An in-flight memory request is abandoned; the memory must tolerate mem_req dropping.
- Spill and fill take effect at the next rising edge.
- fill_data and fill_ack are combinational, so the response comes in the same cycle as the request.
- mem_req rises on the edge after the IDLE decision.
  - mem_addr, mem_we and mem_wdata are registered and stable while mem_req is high.
  - Minimum transaction: mem_req high 1 cycle with mem_ack high in that cycle.
  - Refilled data is visible to fill_ack on the cycle after mem_ack.
- overflow and underflow are registered one-cycle pulses on the edge after the offending cycle.
- mem_count never exceeds MEM_WORDS and never wraps below 0.

## Test plan

Settings: BUF_DEPTH=4, MEM_WORDS=2, spill_base=0x1000.
- Spill 0xA, 0xB, 0xC on consecutive cycles -> mem_req, mem_we=1, addr 0x1000, wdata 0xA. After mem_ack (2-cycle latency): mem_count=1, buf_count=2.
- Continue from that state and fill three times -> 0xC and 0xB acked immediately. A read of 0x1000 returns 0xA on the cycle after mem_ack. Final buf_count=0, mem_count=0.
- fill_req after reset -> underflow pulses once, no fill_ack, no mem_req.
- buf_count=2 with spill 0xD and fill in the same cycle -> fill_data is the old newest word, buf_count stays 2, and a subsequent fill returns 0xD.
- Spill 8 words with mem_ack tied high -> memory holds 2 words, buffer holds 4, and the 7th and 8th spills pulse overflow.
- Assert reset_n low mid-WRITE -> mem_req drops to 0 immediately, and all counts read 0 after reset_n goes high.
